// File: rtl/bus_mem_responder_pkg.sv
// Shared widths, FSM/grant types and the window-decode helper for the burst-bus memory responder.
package bus_mem_responder_pkg;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AW_ACK = 3'd1,
    S_WBEAT  = 3'd2,
    S_WGAP   = 3'd3,
    S_AR_ACK = 3'd4,
    S_RFETCH = 3'd5,
    S_RBEAT  = 3'd6
  } resp_state_e;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

  // Window hit: every address bit above the SRAM index must match the base.
  function automatic logic win_hit(input logic [ADDR_W-1:0] addr,
                                   input logic [ADDR_W-1:0] base,
                                   input int unsigned       depth_log2);
    return (addr >> depth_log2) == (base >> depth_log2);
  endfunction
endpackage

// File: rtl/bus_mem_responder_if.sv
// Burst-bus signal bundle: the initiator drives requests and write data, the responder drives
// ready strobes, write-beat framing and read beats.
interface bus_mem_responder_if;
  import bus_mem_responder_pkg::*;

  logic [ADDR_W-1:0] awaddr;
  logic              awuserap;
  logic [ID_W-1:0]   awuserid;
  logic [LEN_W-1:0]  awlen;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wready;
  logic [ID_W-1:0]   wuserid;
  logic              wlast;
  logic [ADDR_W-1:0] araddr;
  logic              aruserap;
  logic [ID_W-1:0]   aruserid;
  logic [LEN_W-1:0]  arlen;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic [ID_W-1:0]   rid;
  logic              rlast;

  modport master (
    output awaddr, awuserap, awuserid, awlen, awvalid, wdata, wstrb,
    output araddr, aruserap, aruserid, arlen, arvalid,
    input  awready, wready, wuserid, wlast, arready, rdata, rvalid, rid, rlast
  );

  modport slave (
    input  awaddr, awuserap, awuserid, awlen, awvalid, wdata, wstrb,
    input  araddr, aruserap, aruserid, arlen, arvalid,
    output awready, wready, wuserid, wlast, arready, rdata, rvalid, rid, rlast
  );
endinterface

// File: rtl/bus_mem_responder_sram.sv
// Single-port synchronous SRAM with per-byte write enables and one-cycle read latency.
module bus_mem_responder_sram #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [DATA_W/8-1:0]   i_be,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);
  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int i = 0; i < DATA_W / 8; i++) begin
          if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/bus_mem_responder.sv
// Burst-bus responder: serves one AW or AR burst at a time against an internal sync SRAM.
// Optional sticky out-of-window flag (oor_err / oor_clr) when BUS_RESP_OOR_FLAG_EN is defined.
//
// state    | meaning
// IDLE     | waiting for awvalid/arvalid; arbitrates when both are present
// AW_ACK   | awready high; write request fields latched
// WBEAT    | wready high; beat sampled and written if in window
// WGAP     | idle cycle between write beats
// AR_ACK   | arready high; read request fields latched
// RFETCH   | SRAM read of beat 0 in flight
// RBEAT    | rvalid high; next beat's SRAM read issued
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int unsigned       DEPTH_LOG2 = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  bus_mem_responder_if.slave bus
`ifdef BUS_RESP_OOR_FLAG_EN
  ,
  output logic               oor_err,
  input  logic               oor_clr
`endif
);
  resp_state_e       r_state;
  resp_state_e       w_next_state;
  grant_e            r_last_grant;
  logic [ADDR_W-1:0] r_addr;
  logic              r_ap;
  logic [ID_W-1:0]   r_id;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beat;
  logic              r_rd_hit;

  logic              w_hit;
  logic              w_last_beat;
  logic              w_contested;
  logic              w_sram_en;
  logic              w_sram_we;
  logic [DATA_W-1:0] w_sram_q;
  logic              w_awready;
  logic              w_arready;
  logic              w_wready;
  logic              w_wlast;
  logic [ID_W-1:0]   w_wuserid;
  logic              w_rvalid;
  logic              w_rlast;
  logic [ID_W-1:0]   w_rid;
  logic [DATA_W-1:0] w_rdata;

  assign w_hit       = win_hit(r_addr, BASE_ADDR, DEPTH_LOG2);
  assign w_last_beat = (r_beat == r_len);

  always_comb begin
    w_next_state = r_state;
    w_contested  = 1'b0;
    w_sram_en    = 1'b0;
    w_sram_we    = 1'b0;
    w_awready    = 1'b0;
    w_arready    = 1'b0;
    w_wready     = 1'b0;
    w_wlast      = 1'b0;
    w_wuserid    = '0;
    w_rvalid     = 1'b0;
    w_rlast      = 1'b0;
    w_rid        = '0;
    w_rdata      = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.awvalid && bus.arvalid) begin
          w_contested  = 1'b1;
          w_next_state = (r_last_grant == GRANT_RD) ? S_AW_ACK : S_AR_ACK;
        end else if (bus.awvalid) begin
          w_next_state = S_AW_ACK;
        end else if (bus.arvalid) begin
          w_next_state = S_AR_ACK;
        end
      end
      S_AW_ACK: begin
        w_awready    = 1'b1;
        w_next_state = S_WBEAT;
      end
      S_WBEAT: begin
        w_wready     = 1'b1;
        w_wlast      = w_last_beat;
        w_wuserid    = r_id;
        w_sram_en    = w_hit;
        w_sram_we    = 1'b1;
        w_next_state = w_last_beat ? S_IDLE : S_WGAP;
      end
      S_WGAP: begin
        w_wuserid    = r_id;
        w_next_state = S_WBEAT;
      end
      S_AR_ACK: begin
        w_arready    = 1'b1;
        w_next_state = S_RFETCH;
      end
      S_RFETCH: begin
        w_sram_en    = 1'b1;
        w_next_state = S_RBEAT;
      end
      S_RBEAT: begin
        w_rvalid     = 1'b1;
        w_rlast      = w_last_beat;
        w_rid        = r_id;
        w_rdata      = r_rd_hit ? w_sram_q : '0;
        w_sram_en    = 1'b1;
        w_next_state = w_last_beat ? S_IDLE : S_RBEAT;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Arbitration memory only moves on contested grants, so back-to-back contests alternate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= GRANT_RD;
      r_addr       <= '0;
      r_ap         <= 1'b0;
      r_id         <= '0;
      r_len        <= '0;
      r_beat       <= '0;
      r_rd_hit     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_contested) r_last_grant <= (w_next_state == S_AW_ACK) ? GRANT_WR : GRANT_RD;
      case (r_state)
        S_AW_ACK: begin
          r_addr <= bus.awaddr;
          r_ap   <= bus.awuserap;
          r_id   <= bus.awuserid;
          r_len  <= bus.awlen;
          r_beat <= '0;
        end
        S_AR_ACK: begin
          r_addr <= bus.araddr;
          r_ap   <= bus.aruserap;
          r_id   <= bus.aruserid;
          r_len  <= bus.arlen;
          r_beat <= '0;
        end
        S_WBEAT: begin
          r_beat <= r_beat + 1'b1;
          if (r_ap) r_addr <= r_addr + 1'b1;
        end
        S_RFETCH: begin
          r_rd_hit <= w_hit;
          if (r_ap) r_addr <= r_addr + 1'b1;
        end
        S_RBEAT: begin
          r_rd_hit <= w_hit;
          r_beat   <= r_beat + 1'b1;
          if (r_ap) r_addr <= r_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  bus_mem_responder_sram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_sram (
    .clk     (clk),
    .i_en    (w_sram_en),
    .i_we    (w_sram_we),
    .i_be    (bus.wstrb),
    .i_addr  (r_addr[DEPTH_LOG2-1:0]),
    .i_wdata (bus.wdata),
    .o_rdata (w_sram_q)
  );

  assign bus.awready = w_awready;
  assign bus.arready = w_arready;
  assign bus.wready  = w_wready;
  assign bus.wlast   = w_wlast;
  assign bus.wuserid = w_wuserid;
  assign bus.rvalid  = w_rvalid;
  assign bus.rlast   = w_rlast;
  assign bus.rid     = w_rid;
  assign bus.rdata   = w_rdata;

`ifdef BUS_RESP_OOR_FLAG_EN
  logic r_oor_err;
  logic w_oor_beat;

  assign w_oor_beat = ((r_state == S_WBEAT) && !w_hit) || ((r_state == S_RBEAT) && !r_rd_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_oor_err <= 1'b0;
    else if (w_oor_beat) r_oor_err <= 1'b1;
    else if (oor_clr)    r_oor_err <= 1'b0;
  end

  assign oor_err = r_oor_err;
`endif
endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: directed scenarios plus randomized bursts checked
// against a word-array memory model of the responder's window.
module tb_bus_mem_responder;
  localparam int          DEPTH_LOG2 = 10;
  localparam logic [27:0] BASE       = 28'h0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  logic [31:0] mdl [1024];
  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic [31:0] last_rdata;
  bit          mdl_last_wr;

`ifdef BUS_RESP_OOR_FLAG_EN
  logic oor_err;
  logic oor_clr = 1'b0;
`endif

  bus_mem_responder_if bus();

  bus_mem_responder #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef BUS_RESP_OOR_FLAG_EN
    ,
    .oor_err (oor_err),
    .oor_clr (oor_clr)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit in_win(input logic [27:0] a);
    return (a >= BASE) && (a < BASE + 28'd1024);
  endfunction

  function automatic logic [27:0] beat_addr(input logic [27:0] start, input bit ap, input int k);
    return ap ? start + 28'(k) : start;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mdl_last_wr = 1'b0;
  endtask

  task automatic do_write(input logic [27:0] addr, input bit ap, input logic [3:0] id,
                          input int len, output int hs_cyc);
    int n, k;
    logic [27:0] a;
    @(negedge clk);
    bus.awaddr = addr; bus.awuserap = ap; bus.awuserid = id; bus.awlen = 4'(len);
    bus.awvalid = 1'b1; bus.wdata = wr_data[0]; bus.wstrb = wr_strb[0];
    n = 0;
    while (bus.awready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_total++;
    if (bus.awready !== 1'b1) $display("FAIL wr_accept: awready=%b after %0d cycles, required 1", bus.awready, n);
    else n_pass++;
    hs_cyc = cyc;
    @(negedge clk);
    bus.awvalid = 1'b0;
    k = 0;
    for (int c = 0; c < 2 * (len + 1); c++) begin
      if (c % 2 == 0) begin
        n_total++;
        if (bus.wready !== 1'b1 || bus.wlast !== (k == len) || bus.wuserid !== id)
          $display("FAIL wr_beat%0d: wready/wlast/wuserid=%b/%b/%h, required 1/%b/%h",
                   k, bus.wready, bus.wlast, bus.wuserid, (k == len), id);
        else n_pass++;
        a = beat_addr(addr, ap, k);
        if (in_win(a))
          for (int b = 0; b < 4; b++)
            if (wr_strb[k][b]) mdl[int'(a - BASE)][8*b +: 8] = wr_data[k][8*b +: 8];
        k++;
      end else begin
        n_total++;
        if (bus.wready !== 1'b0 || bus.wlast !== 1'b0 || bus.wuserid !== ((c == 2 * len + 1) ? 4'h0 : id))
          $display("FAIL wr_gap%0d: wready/wlast/wuserid=%b/%b/%h, required 0/0/%h",
                   c / 2, bus.wready, bus.wlast, bus.wuserid, (c == 2 * len + 1) ? 4'h0 : id);
        else n_pass++;
      end
      @(negedge clk);
      if (k <= len) begin bus.wdata = wr_data[k]; bus.wstrb = wr_strb[k]; end
    end
  endtask

  task automatic do_read(input logic [27:0] addr, input bit ap, input logic [3:0] id,
                         input int len, output int hs_cyc);
    int n;
    logic [27:0] a;
    logic [31:0] exp_d;
    @(negedge clk);
    bus.araddr = addr; bus.aruserap = ap; bus.aruserid = id; bus.arlen = 4'(len);
    bus.arvalid = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n_total++;
    if (bus.arready !== 1'b1) $display("FAIL rd_accept: arready=%b after %0d cycles, required 1", bus.arready, n);
    else n_pass++;
    hs_cyc = cyc;
    @(negedge clk);
    bus.arvalid = 1'b0;
    n_total++;
    if (bus.rvalid !== 1'b0) $display("FAIL rd_fetch: rvalid=%b one cycle after handshake, required 0", bus.rvalid);
    else n_pass++;
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      a = beat_addr(addr, ap, k);
      exp_d = in_win(a) ? mdl[int'(a - BASE)] : 32'h0;
      n_total++;
      if (bus.rvalid !== 1'b1 || bus.rlast !== (k == len) || bus.rid !== id || bus.rdata !== exp_d)
        $display("FAIL rd_beat%0d @%h: rvalid/rlast/rid/rdata=%b/%b/%h/%h, required 1/%b/%h/%h",
                 k, a, bus.rvalid, bus.rlast, bus.rid, bus.rdata, (k == len), id, exp_d);
      else n_pass++;
      last_rdata = bus.rdata;
    end
    @(negedge clk);
    n_total++;
    if (bus.rvalid !== 1'b0 || bus.rlast !== 1'b0 || bus.rid !== 4'h0 || bus.rdata !== 32'h0)
      $display("FAIL rd_end: rvalid/rlast/rid/rdata=%b/%b/%h/%h, required all 0",
               bus.rvalid, bus.rlast, bus.rid, bus.rdata);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.awready, bus.arready, bus.wready, bus.wlast, bus.wuserid, bus.rvalid, bus.rid, bus.rlast, bus.rdata} !== '0)
      $display("FAIL reset_outputs: %b, required all 0",
               {bus.awready, bus.arready, bus.wready, bus.wlast, bus.wuserid, bus.rvalid, bus.rid, bus.rlast, bus.rdata});
    else n_pass++;
`ifdef BUS_RESP_OOR_FLAG_EN
    n_total++;
    if (oor_err !== 1'b0) $display("FAIL reset_oor: oor_err=%b, required 0", oor_err); else n_pass++;
`endif
    rst_n = 1'b1;
    mdl_last_wr = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.awready, bus.arready, bus.wready, bus.rvalid} !== 4'b0000)
      $display("FAIL idle_outputs: %b, required 0000", {bus.awready, bus.arready, bus.wready, bus.rvalid});
    else n_pass++;
  endtask

  task automatic test_write_burst();
    int hs;
    for (int k = 0; k < 4; k++) begin wr_data[k] = 32'hA0 + 32'(k); wr_strb[k] = 4'hF; end
    do_write(28'h10, 1'b1, 4'h1, 3, hs);
    do_read(28'h10, 1'b1, 4'h2, 3, hs);
    n_total++;
    if (last_rdata !== 32'hA3) $display("FAIL wr_readback: rdata=%h, required 000000a3", last_rdata); else n_pass++;
  endtask

  task automatic test_read_fixed();
    int hs;
    do_read(28'h10, 1'b0, 4'h5, 2, hs);
    n_total++;
    if (last_rdata !== 32'hA0) $display("FAIL rd_fixed: rdata=%h, required 000000a0", last_rdata); else n_pass++;
  endtask

  task automatic test_strobe();
    int hs;
    wr_data[0] = 32'h12345678; wr_strb[0] = 4'hF;
    do_write(28'h20, 1'b0, 4'h3, 0, hs);
    wr_data[0] = 32'hFFFFFFFF; wr_strb[0] = 4'b0101;
    do_write(28'h20, 1'b0, 4'h4, 0, hs);
    do_read(28'h20, 1'b0, 4'h6, 0, hs);
    n_total++;
    if (last_rdata !== 32'h12FF56FF) $display("FAIL strobe: rdata=%h, required 12ff56ff", last_rdata); else n_pass++;
  endtask

  task automatic test_arbitration();
    int hw, hr;
    bit exp_wr_first;
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      wr_data[0] = $urandom; wr_data[1] = $urandom; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
      exp_wr_first = !mdl_last_wr;
      fork
        do_write(28'h30 + 28'(r), 1'b1, 4'(r + 1), 1, hw);
        do_read(28'h10, 1'b1, 4'(r + 8), 3, hr);
      join
      mdl_last_wr = exp_wr_first;
      n_total++;
      if ((hw < hr) !== exp_wr_first)
        $display("FAIL arb_round%0d: write_first=%b, required %b", r, (hw < hr), exp_wr_first);
      else n_pass++;
    end
  endtask

  task automatic test_window();
    int hs;
    wr_data[0] = $urandom; wr_data[1] = $urandom; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    do_write(28'h3FE, 1'b1, 4'h3, 1, hs);
`ifdef BUS_RESP_OOR_FLAG_EN
    n_total++;
    if (oor_err !== 1'b0) $display("FAIL oor_quiet: oor_err=%b, required 0", oor_err); else n_pass++;
`endif
    do_read(28'h3FE, 1'b1, 4'h4, 3, hs);
`ifdef BUS_RESP_OOR_FLAG_EN
    n_total++;
    if (oor_err !== 1'b1) $display("FAIL oor_set: oor_err=%b, required 1", oor_err); else n_pass++;
    oor_clr = 1'b1;
    @(negedge clk);
    oor_clr = 1'b0;
    n_total++;
    if (oor_err !== 1'b0) $display("FAIL oor_clr: oor_err=%b, required 0", oor_err); else n_pass++;
`endif
    // Beat 0 lands outside the window, beat 1 wraps to word 0.
    wr_data[0] = $urandom; wr_data[1] = $urandom;
    do_write(28'hFFFFFFF, 1'b1, 4'h5, 1, hs);
    do_read(28'hFFFFFFF, 1'b1, 4'h6, 1, hs);
    wr_data[0] = $urandom;
    do_write(28'h400, 1'b0, 4'h7, 0, hs);
    do_read(28'h3FF, 1'b1, 4'h8, 1, hs);
  endtask

  task automatic test_reset_mid_burst();
    int n, beats, hs;
    for (int k = 0; k < 8; k++) begin wr_data[k] = $urandom; wr_strb[k] = 4'hF; end
    do_write(28'h40, 1'b1, 4'h2, 7, hs);
    @(negedge clk);
    bus.araddr = 28'h40; bus.aruserap = 1'b1; bus.aruserid = 4'h9; bus.arlen = 4'd7; bus.arvalid = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.arvalid = 1'b0;
    beats = 0; n = 0;
    while (beats < 3 && n < 50) begin
      @(negedge clk);
      n++;
      if (bus.rvalid === 1'b1) beats++;
    end
    n_total++;
    if (beats != 3) $display("FAIL rst_mid_reach: saw %0d beats, required 3", beats); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.rvalid !== 1'b0 || bus.rlast !== 1'b0 || bus.rid !== 4'h0 || bus.rdata !== 32'h0)
      $display("FAIL rst_mid_outputs: rvalid/rlast/rid/rdata=%b/%b/%h/%h, required all 0",
               bus.rvalid, bus.rlast, bus.rid, bus.rdata);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    mdl_last_wr = 1'b0;
    beats = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rvalid !== 1'b0) beats++;
    end
    n_total++;
    if (beats != 0) $display("FAIL rst_mid_quiet: %0d beats after reset, required 0", beats); else n_pass++;
    do_read(28'h40, 1'b1, 4'hC, 7, hs);
  endtask

  task automatic test_random();
    int hs, len;
    logic [27:0] a;
    for (int blk = 0; blk < 6; blk++) begin
      for (int k = 0; k < 16; k++) begin wr_data[k] = $urandom; wr_strb[k] = 4'hF; end
      do_write(28'(blk * 16), 1'b1, 4'(blk), 15, hs);
    end
    for (int t = 0; t < 24; t++) begin
      len = $urandom_range(0, 15);
      a = ($urandom_range(0, 7) == 0) ? 28'h400 + 28'($urandom_range(0, 15)) : 28'($urandom_range(0, 'h4F));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) begin wr_data[k] = $urandom; wr_strb[k] = 4'($urandom_range(0, 15)); end
        do_write(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), len, hs);
      end else begin
        do_read(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), len, hs);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.awaddr = '0; bus.awuserap = 1'b0; bus.awuserid = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0;
    bus.araddr = '0; bus.aruserap = 1'b0; bus.aruserid = '0; bus.arlen = '0; bus.arvalid = 1'b0;
    test_reset();
    test_write_burst();
    test_read_fixed();
    test_strobe();
    test_arbitration();
    test_window();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
